des_subkey_sched: RTL and testbench
===================================

# des_subkey_sched

Iterative DES round-key generator feeding the round datapath (E-expansion, S-box bank, P-permutation) one 48-bit subkey per cycle. It loads a 64-bit key and emits K1..K16 for encryption, or K16..K1 for decryption. Decryption order uses right rotations of C/D, so no subkey storage is needed. Valid/ready handshakes sit on both the key side and the subkey side; one key is processed at a time.

## Interface
- PARITY_CHECK, default 1: 1 = check DES odd parity per key byte; 0 = parity_err tied to 0.
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- key_valid  input  1  key offer.
- key_ready  output  1  block idle and can accept a key.
- key  input  [1:64]  DES key. Bit 1 is the MSB (FIPS 46 numbering); bits 8, 16, ..., 64 are parity.
- decrypt  input  1  sampled with the key: 0 = emit K1..K16, 1 = emit K16..K1.
- sk_valid  output  1  subkey on sk is valid.
- sk_ready  input  1  round datapath consumes sk.
- sk  output  [1:48]  current subkey, in PC-2 output order; bit 1 is the MSB.
- sk_idx  output  4  emission index 0..15. This is the consumer's round step, not the key number.
- sk_last  output  1  high with sk_valid when sk_idx = 15.
- parity_err  output  1  registered at key load; high if any byte has an even count of ones.

## Operation
- States: IDLE and RUN.
- **IDLE**
  - key_ready = 1 and sk_valid = 0.
  - On key_valid & key_ready: compute C0/D0 = PC-1(key) (28 bits each), latch decrypt, update parity_err, and go to RUN with sk_idx = 0.
- **Shift schedule:** SH[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. The SH values sum to 28, so C16/D16 = C0/D0.
- **Encrypt (decrypt = 0)**
  - Cn = rotl(Cn-1, SH[n]) and Dn likewise.
  - Emission j carries Kj+1 = PC-2(Cj+1, Dj+1).
  - The first subkey is PC-2(rotl(C0,1), rotl(D0,1)).
- **Decrypt (decrypt = 1)**
  - The first subkey is K16 = PC-2(C0, D0).
  - After emitting Ki, apply C = rotr(C, SH[i]) and the same to D. Emission j carries K16-j.
- **RUN**
  - sk_valid = 1. sk, sk_idx and sk_last stay stable until sk_valid & sk_ready.
  - On each handshake: advance the C/D registers, load the next sk, and increment sk_idx.
  - The handshake with sk_idx = 15 returns to IDLE.
  - key_ready = 0 throughout RUN; key_valid is ignored.
- sk is a registered output: PC-2 is applied to the next C/D and the result is loaded into the sk register.
- parity_err holds from one load to the next. It does not block subkey generation.

## Timing
- **Reset values:** key_ready 0, sk_valid 0, sk 0, sk_idx 0, sk_last 0, parity_err 0, state IDLE. key_ready goes to 1 in the first cycle after rst drops.
- **Load latency:** key accepted at edge N; sk_valid = 1 with the first subkey from cycle N+1.
- **Throughput:** 1 subkey/cycle while sk_ready is held high. The 16th handshake occurs at edge N+16.
- key_ready = 1 from cycle N+17, so back-to-back keys take 17 cycles each.
- **Back-pressure:** sk_ready low freezes all state. There is no limit on stall length.
- **rst during RUN:** abort at that edge; no further sk_valid; outputs return to reset values.
- A key offered during RUN is not accepted. The source must hold key_valid until key_ready.
- **Same cycle:** a final handshake and a new key_valid cannot both be accepted, because key_ready is 0 in that cycle.

## Test plan
- **Encrypt order:** key 133457799BBCDFF1, decrypt 0, sk_ready held 1.
  - First sk = 1B02EFFC7072 at idx 0, one cycle after load.
  - sk = CB3D8B0E17F5 at idx 15 with sk_last = 1.
  - parity_err = 0.
  - key_ready back to 1 at cycle N+17.
- **Decrypt order:** same key, decrypt 1.
  - idx 0 = CB3D8B0E17F5 and idx 15 = 1B02EFFC7072.
  - All 16 subkeys equal the encrypt sequence reversed.
- **Back-pressure:** random sk_ready (~50%) on the encrypt case.
  - sk and sk_idx stay stable while sk_valid & !sk_ready.
  - The subkey sequence is identical to the no-stall run.
- **Weak key and parity:**
  - Key 0101010101010101: 16 subkeys of 000000000000 and parity_err = 0.
  - Key 0000000000000000: parity_err = 1 and subkeys still emitted.
  - With PARITY_CHECK = 0: parity_err stays 0 for key 0000000000000000.
- **Reset mid-run:** assert rst after 5 handshakes.
  - Next cycle: sk_valid = 0 and sk_idx = 0; key_ready = 1 after rst drops.
  - Reloading the key gives a full 16-subkey sequence.
- **Ignored key:** pulse key_valid with a different key during RUN.
  - It has no effect on the sequence and is not accepted until key_ready = 1.

Source files
------------

// File: rtl/des_subkey_sched_if.sv
// Key-load and subkey-emit handshakes of the DES subkey scheduler.
interface des_subkey_sched_if;
    logic        key_valid;
    logic        key_ready;
    logic [1:64] key;
    logic        decrypt;
    logic        sk_valid;
    logic        sk_ready;
    logic [1:48] sk;
    logic [3:0]  sk_idx;
    logic        sk_last;
    logic        parity_err;

    modport master (
        output key_valid, key, decrypt, sk_ready,
        input  key_ready, sk_valid, sk, sk_idx,
        input  sk_last, parity_err
    );

    modport slave (
        input  key_valid, key, decrypt, sk_ready,
        output key_ready, sk_valid, sk, sk_idx,
        output sk_last, parity_err
    );
endinterface

// File: rtl/des_subkey_sched.sv
// Iterative DES round-key generator: one PC-2 subkey per handshake,
// K1..K16 via left rotations or K16..K1 via right rotations of C/D.
module des_subkey_sched #(
    parameter bit PARITY_CHECK = 1'b1
) (
    input logic               clk,
    input logic               rst,
    des_subkey_sched_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Bit i set means round i+1 shifts by two instead of one.
    localparam logic [0:15] SH2 = 16'b0011_1111_0111_1110;

    function automatic logic [1:56] pc1(input logic [1:64] k);
        logic [1:56] r;
        for (int i = 0; i < 56; i++) r[i+1] = k[PC1_T[i]];
        return r;
    endfunction

    function automatic logic [1:48] pc2(
        input logic [1:28] c,
        input logic [1:28] d
    );
        logic [1:56] cd;
        logic [1:48] r;
        cd = {c, d};
        for (int i = 0; i < 48; i++) r[i+1] = cd[PC2_T[i]];
        return r;
    endfunction

    function automatic logic [1:28] rot(
        input logic [1:28] v,
        input logic        right,
        input logic        two
    );
        logic [1:28] r;
        unique case (1'b1)
            !right && !two: r = {v[2:28], v[1]};
            !right &&  two: r = {v[3:28], v[1:2]};
            right  && !two: r = {v[28], v[1:27]};
            default:        r = {v[27:28], v[1:26]};
        endcase
        return r;
    endfunction

    function automatic logic parity_bad(input logic [1:64] k);
        logic e;
        e = 1'b0;
        for (int b = 0; b < 8; b++)
            if (!(^k[8*b+1 +: 8])) e = 1'b1;
        return e;
    endfunction

    logic [0:0]  state;
    logic [1:28] c_q, d_q;
    logic [1:28] c_ld, d_ld;
    logic [1:28] c_nx, d_nx;
    logic [1:56] cd0;
    logic [1:48] sk_q;
    logic [3:0]  idx_q;
    logic [3:0]  sh_idx;
    logic        dec_q;
    logic        perr_q;
    logic        accept;
    logic        adv;

    assign bus.key_ready  = ~rst & (state == IDLE);
    assign bus.sk_valid   = (state == RUN);
    assign bus.sk         = sk_q;
    assign bus.sk_idx     = idx_q;
    assign bus.sk_last    = (state == RUN) && (idx_q == 4'd15);
    assign bus.parity_err = perr_q;

    assign accept = bus.key_valid & bus.key_ready;
    assign adv    = bus.sk_valid & bus.sk_ready;

    // Encrypt preloads C1/D1; decrypt starts from C0/D0, which equals C16/D16.
    always_comb begin
        cd0    = pc1(bus.key);
        c_ld   = bus.decrypt ? cd0[1:28]
                             : rot(cd0[1:28], 1'b0, 1'b0);
        d_ld   = bus.decrypt ? cd0[29:56]
                             : rot(cd0[29:56], 1'b0, 1'b0);
        sh_idx = dec_q ? 4'd15 - idx_q : idx_q + 4'd1;
        c_nx   = rot(c_q, dec_q, SH2[sh_idx]);
        d_nx   = rot(d_q, dec_q, SH2[sh_idx]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            c_q    <= '0;
            d_q    <= '0;
            sk_q   <= '0;
            idx_q  <= '0;
            dec_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            unique case (1'b1)
                state == IDLE: begin
                    if (accept) begin
                        state  <= RUN;
                        c_q    <= c_ld;
                        d_q    <= d_ld;
                        sk_q   <= pc2(c_ld, d_ld);
                        idx_q  <= '0;
                        dec_q  <= bus.decrypt;
                        perr_q <= PARITY_CHECK && parity_bad(bus.key);
                    end
                end
                default: begin
                    if (adv) begin
                        c_q   <= c_nx;
                        d_q   <= d_nx;
                        sk_q  <= pc2(c_nx, d_nx);
                        idx_q <= idx_q + 4'd1;
                        if (idx_q == 4'd15) state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_des_subkey_sched.sv
// Directed and randomized checks of des_subkey_sched against a
// queue-based DES key schedule model.
module tb_des_subkey_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_assert = 0;
    int n_fail = 0;
    int cyc;
    logic [47:0] got [16];
    logic [47:0] exp_ks [16];
    logic [47:0] enc_ks [16];
    logic [63:0] alt_key;
    logic [63:0] rk;
    bit rdec;
    bit rstall;

    localparam logic [63:0] K_STD = 64'h133457799BBCDFF1;

    des_subkey_sched_if bus();
    des_subkey_sched_if bus2();

    des_subkey_sched #(.PARITY_CHECK(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    des_subkey_sched #(.PARITY_CHECK(1'b0)) dut_np (
        .clk(clk),
        .rst(rst),
        .bus(bus2)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Forward schedule on bit queues; decrypt just stores it reversed.
    function automatic void model(input logic [63:0] k, input bit dec);
        bit c[$];
        bit d[$];
        logic [47:0] s;
        for (int i = 0; i < 28; i++) begin
            c.push_back(k[64 - PC1[i]]);
            d.push_back(k[64 - PC1[28 + i]]);
        end
        for (int r = 0; r < 16; r++) begin
            for (int n = 0; n < SH[r]; n++) begin
                c.push_back(c.pop_front());
                d.push_back(d.pop_front());
            end
            for (int i = 0; i < 48; i++)
                s[47 - i] = (PC2[i] <= 28) ? c[PC2[i] - 1]
                                           : d[PC2[i] - 29];
            exp_ks[dec ? 15 - r : r] = s;
        end
    endfunction

    function automatic logic parity_model(input logic [63:0] k);
        logic e;
        e = 1'b0;
        for (int b = 0; b < 8; b++)
            if ($countones(k[8*b +: 8]) % 2 == 0) e = 1'b1;
        return e;
    endfunction

    task automatic chk(
        input string       tag,
        input logic [63:0] obs,
        input logic [63:0] exp
    );
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [63:0] k, input bit dec);
        int t;
        t = 0;
        while (!bus.key_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("load_ready", bus.key_ready, 1);
        bus.key_valid = 1'b1;
        bus.key       = k;
        bus.decrypt   = dec;
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
    endtask

    task automatic collect(input int nh, input bit stall, input bit ign);
        int n;
        bit held;
        bit rdy;
        logic [47:0] p_sk;
        logic [3:0] p_idx;
        n = 0;
        held = 0;
        cyc = 0;
        p_sk = '0;
        p_idx = '0;
        chk("first_valid", bus.sk_valid, 1);
        while (n < nh && cyc < 2000) begin
            if (held) begin
                chk("stall_sk", bus.sk, p_sk);
                chk("stall_idx", bus.sk_idx, p_idx);
            end
            if (bus.sk_valid) chk("kr_run", bus.key_ready, 0);
            if (ign) begin
                bus.key_valid = 1'($urandom_range(0, 1));
                bus.key       = alt_key;
                bus.decrypt   = 1'($urandom_range(0, 1));
            end
            rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.sk_ready = rdy;
            held = 0;
            if (bus.sk_valid && rdy) begin
                got[n] = bus.sk;
                chk("hs_idx", bus.sk_idx, n);
                chk("hs_last", bus.sk_last, (n == 15));
                n++;
            end else if (bus.sk_valid) begin
                held  = 1;
                p_sk  = bus.sk;
                p_idx = bus.sk_idx;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("hs_count", n, nh);
        bus.sk_ready  = 1'b0;
        bus.key_valid = 1'b0;
    endtask

    initial begin
        bus.key_valid  = 1'b0;
        bus.key        = '0;
        bus.decrypt    = 1'b0;
        bus.sk_ready   = 1'b0;
        bus2.key_valid = 1'b0;
        bus2.key       = '0;
        bus2.decrypt   = 1'b0;
        bus2.sk_ready  = 1'b0;
        alt_key = 64'hFEDCBA9876543210;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_key_ready", bus.key_ready, 0);
        chk("rst_sk_valid", bus.sk_valid, 0);
        chk("rst_sk", bus.sk, 0);
        chk("rst_sk_idx", bus.sk_idx, 0);
        chk("rst_sk_last", bus.sk_last, 0);
        chk("rst_parity", bus.parity_err, 0);
        rst = 1'b0;
        #1;
        chk("rst_drop_ready", bus.key_ready, 1);

        // Encrypt order, known-answer vector
        load(K_STD, 1'b0);
        collect(16, 1'b0, 1'b0);
        chk("enc_cycles", cyc, 16);
        chk("enc_ready_back", bus.key_ready, 1);
        chk("enc_done_valid", bus.sk_valid, 0);
        chk("enc_parity", bus.parity_err, 0);
        chk("enc_k1", got[0], 48'h1B02EFFC7072);
        chk("enc_k16", got[15], 48'hCB3D8B0E17F5);
        model(K_STD, 1'b0);
        for (int j = 0; j < 16; j++) begin
            chk("enc_model", got[j], exp_ks[j]);
            enc_ks[j] = got[j];
        end

        // Decrypt order
        load(K_STD, 1'b1);
        collect(16, 1'b0, 1'b0);
        chk("dec_cycles", cyc, 16);
        chk("dec_first", got[0], 48'hCB3D8B0E17F5);
        chk("dec_last", got[15], 48'h1B02EFFC7072);
        for (int j = 0; j < 16; j++)
            chk("dec_reverse", got[j], enc_ks[15 - j]);

        // Back-pressure
        load(K_STD, 1'b0);
        collect(16, 1'b1, 1'b0);
        for (int j = 0; j < 16; j++)
            chk("bp_seq", got[j], enc_ks[j]);

        // Weak key
        load(64'h0101010101010101, 1'b0);
        collect(16, 1'b0, 1'b0);
        chk("weak_parity", bus.parity_err, 0);
        for (int j = 0; j < 16; j++)
            chk("weak_zero", got[j], 48'h0);

        // All-zero key: bad parity but still emitted
        load(64'h0, 1'b0);
        collect(16, 1'b0, 1'b0);
        chk("zero_parity", bus.parity_err, 1);
        model(64'h0, 1'b0);
        for (int j = 0; j < 16; j++)
            chk("zero_model", got[j], exp_ks[j]);

        // Parity check disabled
        chk("np_ready", bus2.key_ready, 1);
        bus2.sk_ready  = 1'b1;
        bus2.key       = 64'h0;
        bus2.key_valid = 1'b1;
        @(posedge clk); #1;
        bus2.key_valid = 1'b0;
        chk("np_valid", bus2.sk_valid, 1);
        chk("np_parity", bus2.parity_err, 0);

        // Reset mid-run
        load(K_STD, 1'b0);
        collect(5, 1'b0, 1'b0);
        chk("mid_valid", bus.sk_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", bus.sk_valid, 0);
        chk("mid_rst_idx", bus.sk_idx, 0);
        chk("mid_rst_ready", bus.key_ready, 0);
        rst = 1'b0;
        #1;
        chk("mid_ready_back", bus.key_ready, 1);
        load(K_STD, 1'b0);
        collect(16, 1'b0, 1'b0);
        for (int j = 0; j < 16; j++)
            chk("mid_reload", got[j], enc_ks[j]);

        // Key offered during RUN is ignored
        load(64'h0E329232EA6D0D73, 1'b0);
        collect(16, 1'b0, 1'b1);
        chk("ign_done_valid", bus.sk_valid, 0);
        model(64'h0E329232EA6D0D73, 1'b0);
        for (int j = 0; j < 16; j++)
            chk("ign_seq", got[j], exp_ks[j]);
        @(posedge clk); #1;
        chk("ign_no_start", bus.sk_valid, 0);

        // Random keys, direction and stalls
        for (int r = 0; r < 6; r++) begin
            rk     = {$urandom, $urandom};
            rdec   = 1'($urandom_range(0, 1));
            rstall = 1'($urandom_range(0, 1));
            load(rk, rdec);
            collect(16, rstall, 1'b0);
            chk("rnd_parity", bus.parity_err, parity_model(rk));
            model(rk, rdec);
            for (int j = 0; j < 16; j++)
                chk("rnd_seq", got[j], exp_ks[j]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
